// File: rtl/contador_ctrl_if.sv
// Bus between contador_ctrl, its two requesters and the shared 16-bit down counter.
// master = requester/counter side, slave = the scheduler.
interface contador_ctrl_if #(
  parameter int N = 16
);
  logic         REQ_A;
  logic         REQ_B;
  logic [N-1:0] PERIOD_A;
  logic [N-1:0] PERIOD_B;
  logic         ABORT;
  logic [N-1:0] Q;
  logic [1:0]   MODO;
  logic         ENB;
  logic [N-1:0] D;
  logic         GNT_A;
  logic         GNT_B;
  logic         DONE_A;
  logic         DONE_B;
  logic         BUSY;

  modport master (
    output REQ_A, REQ_B, PERIOD_A, PERIOD_B, ABORT, Q,
    input  MODO, ENB, D, GNT_A, GNT_B, DONE_A, DONE_B, BUSY
  );

  modport slave (
    input  REQ_A, REQ_B, PERIOD_A, PERIOD_B, ABORT, Q,
    output MODO, ENB, D, GNT_A, GNT_B, DONE_A, DONE_B, BUSY
  );
endinterface

// File: rtl/contador_ctrl.sv
// Round-robin timer scheduler: grants the shared down counter to A or B, loads the
// winner's period, counts it to zero and returns a one-cycle done pulse to the winner.
module contador_ctrl #(
  parameter int N = 16
) (
  input logic             CLK,
  input logic             RESET_L,
  contador_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t       state, state_nxt;
  logic         last_b;
  logic         win_a;
  logic [N-1:0] period_q;
  logic [1:0]   modo_q;
  logic         gnt_a, gnt_b;
  logic         done_a, done_b;
  logic         busy_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.REQ_A || bus.REQ_B) state_nxt = LOAD;
      LOAD:  state_nxt = bus.ABORT ? IDLE : COUNT;
      COUNT: begin
        // abort wins over a simultaneous terminal count
        if (bus.ABORT)        state_nxt = IDLE;
        else if (bus.Q == '0) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
    endcase
  end

  // A wins alone, or on a tie when B was served last
  assign win_a = bus.REQ_A && (!bus.REQ_B || last_b);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      period_q <= '0;
      modo_q   <= 2'b00;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOAD) begin
        gnt_a    <= win_a;
        gnt_b    <= !win_a;
        last_b   <= !win_a;
        period_q <= win_a ? bus.PERIOD_A : bus.PERIOD_B;
      end else if (state_nxt == IDLE) begin
        gnt_a <= 1'b0;
        gnt_b <= 1'b0;
      end
      unique case (state_nxt)
        IDLE:    modo_q <= 2'b00;
        LOAD:    modo_q <= 2'b11;
        default: modo_q <= 2'b01;
      endcase
      // grant is stable on entry to DONE, so the pulse goes to the current owner
      done_a <= (state_nxt == DONE) && gnt_a;
      done_b <= (state_nxt == DONE) && gnt_b;
      busy_q <= (state_nxt != IDLE);
    end
  end

  assign bus.MODO   = modo_q;
  assign bus.D      = period_q;
  assign bus.GNT_A  = gnt_a;
  assign bus.GNT_B  = gnt_b;
  assign bus.DONE_A = done_a;
  assign bus.DONE_B = done_b;
  assign bus.BUSY   = busy_q;
  // the counter only moves while an operation is owned and not being aborted
  assign bus.ENB    = !bus.ABORT &&
                      ((state == LOAD) || (state == COUNT && bus.Q != '0));

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: behavioural counter plus a grant-timestamp reference model,
// driven by directed scenarios followed by random requests, periods, aborts and resets.
module tb_contador_ctrl;

  localparam int N = 16;

  logic         CLK = 1'b0;
  logic         RESET_L = 1'b0;
  logic [N-1:0] cnt_q = '0;
  int           n_chk = 0;
  int           n_err = 0;

  contador_ctrl_if #(.N(N)) bus ();

  contador_ctrl #(.N(N)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  // behavioural 16-bit counter: not touched by RESET_L, so Q survives a reset
  assign bus.Q = cnt_q;
  always @(posedge CLK) begin
    if (bus.ENB) begin
      case (bus.MODO)
        2'b11:   cnt_q <= bus.D;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        2'b10:   cnt_q <= cnt_q + 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // reference: owner (0 none, 1 A, 2 B), edges since grant, granted period
  int ref_own, ref_k, ref_p, ref_d;
  bit ref_last_b;

  task automatic model_reset();
    ref_own = 0; ref_k = 0; ref_p = 0; ref_d = 0; ref_last_b = 1'b1;
  endtask

  task automatic model_edge();
    bit wa;
    if (!RESET_L) begin
      model_reset();
    end else if (ref_own == 0) begin
      if (bus.REQ_A || bus.REQ_B) begin
        wa = bus.REQ_A && (!bus.REQ_B || ref_last_b);
        ref_own    = wa ? 1 : 2;
        ref_last_b = !wa;
        ref_p      = wa ? int'(bus.PERIOD_A) : int'(bus.PERIOD_B);
        ref_d      = ref_p;
        ref_k      = 0;
      end
    end else if (ref_k <= ref_p + 1 && bus.ABORT) begin
      ref_own = 0;
    end else if (ref_k == ref_p + 2) begin
      ref_own = 0;
    end else begin
      ref_k++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    int  e_modo, e_enb, e_da, e_db;
    e_modo = 0; e_enb = 0; e_da = 0; e_db = 0;
    if (ref_own != 0) begin
      if (ref_k == 0) begin
        e_modo = 3;
        e_enb  = bus.ABORT ? 0 : 1;
      end else if (ref_k <= ref_p + 1) begin
        e_modo = 1;
        e_enb  = ((ref_p - (ref_k - 1)) != 0 && !bus.ABORT) ? 1 : 0;
        chk("q_count", 32'(bus.Q), 32'(ref_p - (ref_k - 1)));
      end else begin
        e_modo = 1;
        e_da   = (ref_own == 1) ? 1 : 0;
        e_db   = (ref_own == 2) ? 1 : 0;
      end
    end
    chk("modo",   32'(bus.MODO),   32'(e_modo));
    chk("enb",    32'(bus.ENB),    32'(e_enb));
    chk("d",      32'(bus.D),      32'(ref_d));
    chk("gnt_a",  32'(bus.GNT_A),  32'(ref_own == 1));
    chk("gnt_b",  32'(bus.GNT_B),  32'(ref_own == 2));
    chk("done_a", 32'(bus.DONE_A), 32'(e_da));
    chk("done_b", 32'(bus.DONE_B), 32'(e_db));
    chk("busy",   32'(bus.BUSY),   32'(ref_own != 0));
  endtask

  // one clock: drive inputs just after an edge, check, then advance model at next edge
  task automatic cycle(input logic rst_n, input logic ra, input logic rb,
                       input logic [N-1:0] pa, input logic [N-1:0] pb, input logic ab);
    #1;
    RESET_L      = rst_n;
    bus.REQ_A    = ra;
    bus.REQ_B    = rb;
    bus.PERIOD_A = pa;
    bus.PERIOD_B = pb;
    bus.ABORT    = ab;
    if (!rst_n) model_reset();
    #1;
    check_all();
    @(posedge CLK);
    model_edge();
  endtask

  initial begin
    model_reset();
    bus.REQ_A = 1'b1; bus.REQ_B = 1'b0; bus.ABORT = 1'b0;
    bus.PERIOD_A = 16'd5; bus.PERIOD_B = 16'd0;
    @(posedge CLK);
    model_edge();

    // reset held with REQ_A up, then A with period 5
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'd5, 16'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'd5, 16'd0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 16'd5, 16'd0, 1'b0);

    // both requesting continuously: alternating grants
    repeat (30) cycle(1'b1, 1'b1, 1'b1, 16'd3, 16'd2, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 16'd3, 16'd2, 1'b0);

    // zero period on B
    cycle(1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

    // abort A (period 10) when Q reaches 6 while B waits
    cycle(1'b1, 1'b1, 1'b0, 16'd10, 16'd4, 1'b0);
    repeat (16) cycle(1'b1, 1'b0, 1'b1, 16'd10, 16'd4,
                      logic'(ref_own == 1 && ref_k == 5));
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 16'd10, 16'd4, 1'b0);

    // period changed mid-operation has no effect
    cycle(1'b1, 1'b1, 1'b0, 16'd8, 16'd0, 1'b0);
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 16'd2, 16'd0, 1'b0);

    // reset in the middle of a count
    cycle(1'b1, 1'b1, 1'b0, 16'd9, 16'd0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 16'd9, 16'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'd9, 16'd0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 16'd9, 16'd0, 1'b0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(logic'($urandom_range(0, 299) != 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 40)) : N'($urandom_range(0, 6)),
            ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 40)) : N'($urandom_range(0, 6)),
            logic'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
# contador_ctrl

Two-requester timer scheduler that owns the 16-bit `contador_de16_bits` counter and shares it between requesters A and B. It arbitrates round-robin between requesters, loads the winner's period into the counter, and drives the counter down to zero. It then returns a one-cycle done pulse to the winner. All counter control (MODO, ENB, D) comes from this block; the counter's Q feeds back as the completion condition.

## Interface
- N, 16, counter and period width; must equal the counter's N.

- CLK  in  1  rising-edge clock shared with the counter
- RESET_L  in  1  asynchronous, active-low reset
- REQ_A, REQ_B  in  1  level requests; sampled only in IDLE
- PERIOD_A, PERIOD_B  in  N  countdown period; captured at grant
- ABORT  in  1  cancels the current operation
- Q  in  N  counter output
- MODO  out  2  counter mode: 11 = load D, 01 = count down, 00 = hold mode
- ENB  out  1  counter enable
- D  out  N  counter load value (the captured period)
- GNT_A, GNT_B  out  1  owner indication, one-hot or zero
- DONE_A, DONE_B  out  1  one-cycle completion pulse
- BUSY  out  1  high in every state except IDLE

## Operation
- States and outputs:
  - IDLE: MODO=00, ENB=0.
  - LOAD: MODO=11, ENB=1, D=period_q.
  - COUNT: MODO=01, ENB=(Q!=0)&&!ABORT (combinational).
  - DONE: MODO=01, ENB=0.
- Transitions:
  - IDLE → LOAD when REQ_A|REQ_B.
  - LOAD → COUNT unconditionally, unless ABORT.
  - COUNT → DONE when Q==0.
  - DONE → IDLE always.
  - LOAD/COUNT → IDLE when ABORT=1. Abort takes priority over Q==0. No DONE pulse on abort.
- Arbitration happens at the IDLE→LOAD edge. Action at that edge:
  - Set the winner's GNT.
  - Copy its PERIOD_x into period_q.
  - Update last_gnt.
- Arbitration rule:
  - Only one requester → it wins.
  - Both requesting → the requester other than last_gnt wins.
  - last_gnt resets to B, so A wins the first tie.
- GNT_x stays high through LOAD, COUNT and DONE. It clears on entry to IDLE.
- DONE_x = (state==DONE) && GNT_x. It is registered-state derived and glitch-free.
- REQ_x and PERIOD_x are ignored outside IDLE. Requester changes mid-operation have no effect.
- REQ held high through DONE re-arbitrates in the following IDLE cycle. Round-robin then favours the other requester if it is also requesting.
- Period 0: load 0, COUNT sees Q==0 immediately, ENB stays 0, DONE follows.
- Counter parity and RCO are unused.

## Timing
- Reset (asynchronous, immediate):
  - State: IDLE.
  - Outputs: MODO=00, ENB=0, D=0, GNT_A=GNT_B=0, DONE_A=DONE_B=0, BUSY=0.
  - Internal: period_q=0, last_gnt=B.
- Reset mid-operation abandons the transfer. No DONE pulse is produced; the counter keeps its Q.
- Sequence for period P, with REQ sampled at edge t0:
  - Cycle after t0: LOAD. Edge t1 loads the counter; Q=P after t1.
  - COUNT lasts from t1 to t1+P. Q decrements each edge and reaches 0 after edge t1+P.
  - DONE covers the cycle after edge t1+P+1.
  - IDLE after edge t1+P+2.
- Latency:
  - Request sample edge to DONE pulse edge: P+2 clocks.
  - Minimum turnaround between grants: P+4 clocks, including one mandatory IDLE cycle.
- ABORT:
  - Combinationally forces ENB=0 in the same cycle.
  - State is IDLE and GNT clears after the next edge.
  - Q is frozen at its current value.
- ENB never rises in IDLE or DONE, so the counter never moves outside an owned operation.

## Test plan
- Reset with REQ_A=1 asserted: all outputs are 0 during reset. After release, GNT_A rises one edge later and MODO=11, D=PERIOD_A.
- REQ_A=1, PERIOD_A=5, B idle:
  - LOAD 1 cycle; Q=5,4,3,2,1,0.
  - DONE_A high for exactly 1 cycle, 7 clocks after the sample edge.
  - BUSY falls the next cycle.
- REQ_A=REQ_B=1 continuously, PERIOD_A=3, PERIOD_B=2: grants alternate A,B,A,B. Each DONE is followed by one IDLE cycle; DONE_A and DONE_B are never simultaneous.
- PERIOD_B=0, REQ_B only: LOAD, one COUNT cycle with ENB=0, then DONE_B. Q stays 0 throughout.
- ABORT mid-count (PERIOD_A=10, abort when Q=6):
  - ENB=0 in the abort cycle; Q holds 6.
  - IDLE next; no DONE_A.
  - A pending REQ_B is granted on the following edge.
- PERIOD_A changed from 8 to 2 during COUNT: the count continues to 0 from 8. D remains 8 until the operation ends.
